// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_e;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-cycle-latency memory.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants; default is data priority with a burst limit.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_D_BURST = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state, state_nxt;
   logic              d_win;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Requester that wins the next tie; flips to the other side after every grant.
   logic rr_prio;

   assign d_win = d_req && (!if_req || rr_prio == REQ_D);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)       rr_prio <= REQ_IF;
      else if (if_gnt) rr_prio <= REQ_D;
      else if (d_gnt)  rr_prio <= REQ_IF;
   end
`else
   localparam int CNT_W = $clog2(MAX_D_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_BURST);

   logic [CNT_W-1:0] d_burst_cnt;

   // Data wins ties until it has starved a waiting fetch for MAX_D_BURST grants.
   assign d_win = d_req && !(if_req && d_burst_cnt == CNT_MAX);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                             d_burst_cnt <= '0;
      else if (if_gnt || !if_req)            d_burst_cnt <= '0;
      else if (d_gnt && d_burst_cnt != CNT_MAX) d_burst_cnt <= d_burst_cnt + 1'b1;
   end
`endif

   // Grants are suppressed while reset is asserted so no access leaks out during reset.
   assign d_gnt  = nrst && d_win;
   assign if_gnt = nrst && if_req && !d_win;

   // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
   always_comb begin
      state_nxt = IDLE;
      mem_raddr = '0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_wen   = 1'b0;
      if (if_gnt) begin
         mem_raddr = if_addr;
         state_nxt = SERVE_I;
      end else if (d_gnt) begin
         if (d_we) begin
            mem_wen   = 1'b1;
            mem_waddr = d_addr;
            mem_wdata = d_wdata;
         end else begin
            mem_raddr = d_addr;
            state_nxt = SERVE_D;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   assign if_rvalid = (state == SERVE_I);
   assign d_rvalid  = (state == SERVE_D);

   // NOTE: the held read-data registers are plain flops, so they take the reset and clear to zero.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (if_rvalid) if_rdata_q <= mem_rdata;
         if (d_rvalid)  d_rdata_q  <= mem_rdata;
      end
   end

   assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
   assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;

endmodule
